// File: rtl/io_frc_mc.sv
// Multi-channel free-run timer on the IO bus: per-channel prescaled counter,
// compare/match with one-shot or periodic mode, sticky pending flags and IRQs.

module io_frc_mc_ch #(
  parameter int CNT_W   = 40,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_reg,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_reg,
  input  logic        rd_lat,
  output logic [31:0] rd_val,
  output logic        pend,
  output logic        ie
);
  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [HI_W-1:0]    shadow_q, shadow_d;
  logic               run_q, run_d;
  logic               mode_q, mode_d;
  logic               ie_q, ie_d;
  logic               pend_q, pend_d;

  logic wr_vallo, wr_valhi, wr_cmplo, wr_cmphi, wr_cntrl, wr_stat, wr_presc;
  logic crst, val_wr, tick, match, match_eff;

  always_comb begin
    wr_vallo  = wr_en & (wr_reg == 3'd0);
    wr_valhi  = wr_en & (wr_reg == 3'd1);
    wr_cmplo  = wr_en & (wr_reg == 3'd2);
    wr_cmphi  = wr_en & (wr_reg == 3'd3);
    wr_cntrl  = wr_en & (wr_reg == 3'd4);
    wr_stat   = wr_en & (wr_reg == 3'd5);
    wr_presc  = wr_en & (wr_reg == 3'd6);
    crst      = wr_cntrl & wdata[1];
    val_wr    = wr_vallo | wr_valhi;
    tick      = run_q & (pc_q == presc_q);
    match     = tick & (cnt_q == cmp_q);
    // a match only acts when the counter is not being overridden by software
    match_eff = match & ~crst & ~val_wr;
  end

  always_comb begin
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    presc_d  = presc_q;
    pc_d     = pc_q;
    shadow_d = shadow_q;
    run_d    = run_q;
    mode_d   = mode_q;
    ie_d     = ie_q;
    pend_d   = pend_q;

    if (!run_q || tick || crst || wr_presc) pc_d = '0;
    else                                     pc_d = pc_q + PRESC_W'(1);

    if (crst) begin
      cnt_d = '0;
    end else if (val_wr) begin
      if (wr_vallo) cnt_d[31:0]      = wdata;
      if (wr_valhi) cnt_d[CNT_W-1:32] = wdata[HI_W-1:0];
    end else if (match) begin
      if (mode_q) cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (match_eff && !mode_q) run_d = 1'b0;
    if (wr_cntrl) begin
      run_d  = wdata[0];
      mode_d = wdata[3];
      ie_d   = wdata[4];
    end

    // set beats clear when both land in the same cycle
    if (wr_stat && wdata[0]) pend_d = 1'b0;
    if (match_eff)           pend_d = 1'b1;

    if (wr_cmplo) cmp_d[31:0]       = wdata;
    if (wr_cmphi) cmp_d[CNT_W-1:32] = wdata[HI_W-1:0];
    if (wr_presc) presc_d           = wdata[PRESC_W-1:0];
    if (rd_lat)   shadow_d          = cnt_q[CNT_W-1:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cmp_q    <= '0;
      presc_q  <= '0;
      pc_q     <= '0;
      shadow_q <= '0;
      run_q    <= 1'b0;
      mode_q   <= 1'b0;
      ie_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      presc_q  <= presc_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
      run_q    <= run_d;
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_reg)
      3'd0: rd_val = cnt_q[31:0];
      3'd1: rd_val = 32'(shadow_q);
      3'd2: rd_val = cmp_q[31:0];
      3'd3: rd_val = 32'(cmp_q[CNT_W-1:32]);
      3'd4: rd_val = {27'd0, ie_q, mode_q, 2'b00, run_q};
      3'd5: rd_val = {31'd0, pend_q};
      3'd6: rd_val = 32'(presc_q);
      default: rd_val = '0;
    endcase
  end

  assign pend = pend_q;
  assign ie   = ie_q;
endmodule

module io_frc_mc #(
  parameter int          NCH      = 2,
  parameter int          CNT_W    = 40,
  parameter int          PRESC_W  = 8,
  parameter logic [13:0] BASE_ADR = 14'h3E00
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           dma_io_we,
  input  logic [15:2]    dma_io_wadr,
  input  logic [31:0]    dma_io_wdata,
  input  logic [15:2]    dma_io_radr,
  input  logic           dma_io_radr_en,
  input  logic [31:0]    dma_io_rdata_in,
  output logic [31:0]    dma_io_rdata,
  input  logic           csr_mtie,
  output logic [NCH-1:0] frc_irq_ch,
  output logic           frc_irq
);
  localparam logic [13:0] SPAN    = 14'(8 * NCH);
  localparam logic [13:0] GLB_ADR = BASE_ADR + 14'h3F;

  logic [13:0] wr_off, rd_off;
  logic        wr_in, rd_in, rd_glb, hit;
  logic [NCH-1:0]       wr_en, rd_lat, pend_vec, ie_vec;
  logic [NCH-1:0][31:0] rd_val;
  logic [31:0]          rd_sel;

  logic [31:0]    rdata_q, rdata_d;
  logic           hit_q, hit_d;
  logic [NCH-1:0] irq_ch_q, irq_ch_d;
  logic           irq_q, irq_d;

  always_comb begin
    wr_off = dma_io_wadr - BASE_ADR;
    rd_off = dma_io_radr - BASE_ADR;
    wr_in  = wr_off < SPAN;
    rd_in  = rd_off < SPAN;
    rd_glb = dma_io_radr == GLB_ADR;
    hit    = dma_io_radr_en & (rd_in | rd_glb);
    wr_en  = '0;
    rd_lat = '0;
    rd_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_off[13:3] == 11'(c)) wr_en[c] = dma_io_we & wr_in;
      if (rd_off[13:3] == 11'(c)) begin
        rd_lat[c] = dma_io_radr_en & rd_in & (rd_off[2:0] == 3'd0);
        rd_sel    = rd_val[c];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    io_frc_mc_ch #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[c]),
      .wr_reg (wr_off[2:0]),
      .wdata  (dma_io_wdata),
      .rd_reg (rd_off[2:0]),
      .rd_lat (rd_lat[c]),
      .rd_val (rd_val[c]),
      .pend   (pend_vec[c]),
      .ie     (ie_vec[c])
    );
  end

  always_comb begin
    hit_d    = hit;
    rdata_d  = rdata_q;
    if (hit) rdata_d = rd_glb ? 32'(pend_vec) : rd_sel;
    irq_ch_d = pend_vec & ie_vec;
    irq_d    = (|(pend_vec & ie_vec)) & csr_mtie;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      irq_ch_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      irq_ch_q <= irq_ch_d;
      irq_q    <= irq_d;
    end
  end

  // misses fall straight through to the downstream slave's data
  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;
  assign frc_irq_ch   = irq_ch_q;
  assign frc_irq      = irq_q;
endmodule

// File: tb/tb_io_frc_mc.sv
// Directed bench for io_frc_mc: periodic/one-shot, prescaler, shadow reads,
// W1C vs match, read pass-through and asynchronous reset.

module tb_io_frc_mc;
  localparam int          NCH     = 2;
  localparam int          CNT_W   = 40;
  localparam int          PRESC_W = 8;
  localparam logic [13:0] B       = 14'h3E00;

  logic           clk;
  logic           rst_n;
  logic           dma_io_we;
  logic [15:2]    dma_io_wadr;
  logic [31:0]    dma_io_wdata;
  logic [15:2]    dma_io_radr;
  logic           dma_io_radr_en;
  logic [31:0]    dma_io_rdata_in;
  logic [31:0]    dma_io_rdata;
  logic           csr_mtie;
  logic [NCH-1:0] frc_irq_ch;
  logic           frc_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  io_frc_mc #(.NCH(NCH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .BASE_ADR(B)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_radr_en  (dma_io_radr_en),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .csr_mtie        (csr_mtie),
    .frc_irq_ch      (frc_irq_ch),
    .frc_irq         (frc_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ra(input int ch, input int off);
    return B + 14'(8 * ch + off);
  endfunction

  task automatic wr(input logic [13:0] a, input logic [31:0] v);
    dma_io_we = 1'b1; dma_io_wadr = a; dma_io_wdata = v;
    @(posedge clk); #1;
    dma_io_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] v);
    dma_io_radr_en = 1'b1; dma_io_radr = a;
    @(posedge clk); #1;
    dma_io_radr_en = 1'b0;
    v = dma_io_rdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
    dma_io_radr = '0; dma_io_radr_en = 1'b0; dma_io_rdata_in = 32'hDEADBEEF;
    csr_mtie = 1'b0;
    #1;
    check("rst irq", frc_irq, 0);
    check("rst irq_ch", frc_irq_ch, 0);
    check("rst rdata passthru", dma_io_rdata, 32'hDEADBEEF);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rd(ra(0, 4), d); check("rst ch0 cntrl", d, 0);
    rd(ra(1, 0), d); check("rst ch1 vallo", d, 0);

    // 1: ch0 periodic, compare 5
    csr_mtie = 1'b1;
    wr(ra(0, 2), 32'd5);
    wr(ra(0, 4), 32'h19);
    for (int k = 1; k <= 8; k++) begin
      rd(ra(0, 0), d);
      check("t1 cnt", d, 64'((k - 1) % 6));
      check("t1 irq", frc_irq, 64'(k >= 7));
    end
    wr(ra(0, 5), 32'h1);
    check("t1 irq before clr", frc_irq, 1);
    cyc(1); check("t1 irq clr1", frc_irq, 0);
    cyc(1); check("t1 irq clr2", frc_irq, 0);
    cyc(2); check("t1 irq recycle", frc_irq, 1);

    // 2: ch1 one-shot with prescaler 3
    wr(ra(1, 6), 32'd3);
    wr(ra(1, 2), 32'd2);
    wr(ra(1, 4), 32'h01);
    for (int k = 1; k <= 14; k++) begin
      rd(ra(1, 0), d);
      check("t2 cnt", d, 64'(((k - 1) / 4) > 2 ? 2 : (k - 1) / 4));
    end
    rd(ra(1, 4), d); check("t2 ch1 cntrl", d, 32'h00);
    rd(ra(1, 5), d); check("t2 ch1 stat", d, 32'h1);
    rd(ra(1, 6), d); check("t2 ch1 presc", d, 32'd3);
    rd(ra(0, 4), d); check("t2 ch0 cntrl", d, 32'h19);
    check("t2 ch1 irq gated by ie", frc_irq_ch[1], 0);

    // 5: global STAT, miss pass-through, reserved offset
    rd(B + 14'h3F, d); check("t5 glb stat", d, 32'h3);
    dma_io_rdata_in = 32'hA5A5A5A5;
    rd(14'h3000, d); check("t5 miss", d, 32'hA5A5A5A5);
    wr(ra(0, 7), 32'hFFFFFFFF);
    rd(ra(0, 7), d); check("t5 reserved", d, 32'h0);
    cyc(1);
    dma_io_rdata_in = 32'h5A5A0000; #1;
    check("t5 idle passthru", dma_io_rdata, 32'h5A5A0000);

    // 4: W1C and match on the same edge
    wr(ra(0, 4), 32'h1B);
    cyc(5);
    wr(ra(0, 5), 32'h1);
    check("t4 irq_ch0 a", frc_irq_ch[0], 1);
    cyc(1);
    check("t4 irq_ch0 b", frc_irq_ch[0], 1);
    check("t4 irq", frc_irq, 1);
    rd(ra(0, 5), d); check("t4 pend", d, 32'h1);
    rd(ra(0, 4), d); check("t4 crst reads 0", d, 32'h19);
    rd(ra(0, 0), d); check("t4 cnt after crst", d, 32'd3);

    // 3a: coherent VALLO/VALHI across a carry
    wr(ra(1, 4), 32'h0);
    wr(ra(1, 5), 32'h1);
    wr(ra(1, 2), 32'h0);
    wr(ra(1, 3), 32'h80);
    wr(ra(1, 6), 32'h0);
    wr(ra(1, 1), 32'h12);
    wr(ra(1, 0), 32'hFFFFFFFD);
    wr(ra(1, 4), 32'h01);
    cyc(2);
    rd(ra(1, 0), d); check("t3 lo", d, 32'hFFFFFFFF);
    rd(ra(1, 1), d); check("t3 hi shadow", d, 32'h12);
    rd(ra(1, 0), d); check("t3 lo2", d, 32'h1);
    rd(ra(1, 1), d); check("t3 hi2", d, 32'h13);

    // 3b: all-ones wraps silently, then matches compare 0
    wr(ra(1, 4), 32'h0);
    wr(ra(1, 3), 32'h0);
    wr(ra(1, 0), 32'hFFFFFFFF);
    wr(ra(1, 1), 32'hFF);
    wr(ra(1, 5), 32'h1);
    wr(ra(1, 4), 32'h11);
    cyc(1); check("t3 wrap no irq", frc_irq_ch[1], 0);
    cyc(1); check("t3 irq lag", frc_irq_ch[1], 0);
    cyc(1); check("t3 irq", frc_irq_ch[1], 1);
    rd(ra(1, 0), d); check("t3 cnt lo 0", d, 32'h0);
    rd(ra(1, 1), d); check("t3 cnt hi 0", d, 32'h0);
    rd(ra(1, 4), d); check("t3 cntrl", d, 32'h10);
    rd(ra(1, 5), d); check("t3 stat", d, 32'h1);

    // 6: asynchronous reset mid-cycle
    check("t6 irq pre", frc_irq, 1);
    rd(ra(0, 4), d); check("t6 cntrl pre", d, 32'h19);
    #1 rst_n = 1'b0;
    #1;
    check("t6 irq", frc_irq, 0);
    check("t6 irq_ch", frc_irq_ch, 0);
    check("t6 rdata", dma_io_rdata, 32'h5A5A0000);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(3);
    rd(ra(0, 0), d); check("t6 cnt", d, 0);
    rd(ra(0, 4), d); check("t6 cntrl", d, 0);
    rd(ra(0, 5), d); check("t6 stat", d, 0);
    rd(ra(0, 2), d); check("t6 cmplo", d, 0);
    rd(ra(1, 1), d); check("t6 shadow", d, 0);
    rd(B + 14'h3F, d); check("t6 glb", d, 0);
    rd(ra(0, 0), d); check("t6 cnt held", d, 0);
    check("t6 irq post", frc_irq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
